// File: rtl/countdown_timer_ctrl.sv
// countdown_timer_ctrl
//   Sequences an external 4-bit synchronous down-counter (parallel load,
//   count enable, synchronous clear) and the blanking/lamp-test inputs of its
//   display decoder. The counter is loaded with a preset and then ticked down
//   once every TICK_DIV clock cycles until it reads zero. The display then
//   flashes until the next start or a clear.
//
//   State table:
//     state    | meaning
//     ---------+-----------------------------------------------------------
//     ST_IDLE  | waiting for a start edge, prescaler parked at 0
//     ST_LOAD  | one cycle, PEn low, counter loads the captured preset
//     ST_RUN   | prescaler running, CEP pulse on each wrap while q != 0
//     ST_PAUSE | prescaler frozen, no CEP, waiting for a pause edge
//     ST_DONE  | counter reached 0, display blinks at the tick rate
//
// Parameters
//   TICK_DIV  clock cycles per count tick (2 .. 2**PRESC_W)
//   PRESC_W   prescaler width
// Ports
//   CP         system clock, rising edge
//   rstn       asynchronous reset, active low
//   start      level; rising edge starts or restarts the countdown
//   pause      level; rising edge toggles run/pause
//   clear      level; synchronous abort to idle, clears the counter
//   lamp_test  display lamp test request, active high
//   preset     countdown start value
//   q          current value of the external counter
//   D          parallel-load data to the counter
//   PEn        counter parallel load, active low
//   CEP        counter count enable, one cycle per tick
//   MRn        counter synchronous clear, active low
//   LTN        decoder lamp test, active low
//   BIN        decoder blanking, active low
//   busy       high in LOAD, RUN, PAUSE
//   done       high in DONE
module countdown_timer_ctrl #(
   parameter int TICK_DIV = 50000000,
   parameter int PRESC_W  = 26
) (
   input  logic       CP,
   input  logic       rstn,
   input  logic       start,
   input  logic       pause,
   input  logic       clear,
   input  logic       lamp_test,
   input  logic [3:0] preset,
   input  logic [3:0] q,
   output logic [3:0] D,
   output logic       PEn,
   output logic       CEP,
   output logic       MRn,
   output logic       LTN,
   output logic       BIN,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_PAUSE,
      ST_DONE
   } state_t;

   localparam logic [PRESC_W-1:0] PRESC_TC  = PRESC_W'(TICK_DIV - 1);
   localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

   state_t               state_q, state_d;
   logic [PRESC_W-1:0]   presc_q, presc_d;
   logic [3:0]           d_q, d_d;
   logic                 blink_q, blink_d;
   logic                 start_dly_q, start_dly_d;
   logic                 pause_dly_q, pause_dly_d;
   logic                 start_arm_q, start_arm_d;

   logic                 start_edge;
   logic                 pause_edge;
   logic                 presc_wrap;
   logic [PRESC_W-1:0]   presc_inc;
   logic                 q_zero;

   // start_arm keeps a start level that is already high when reset releases
   // from being taken as an edge; it arms once start has been seen low.
   assign start_edge = start & ~start_dly_q & start_arm_q;
   assign pause_edge = pause & ~pause_dly_q;
   assign presc_wrap = (presc_q == PRESC_TC);
   assign presc_inc  = presc_wrap ? '0 : presc_q + PRESC_ONE;
   assign q_zero     = (q == 4'd0);

   always_ff @(posedge CP or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         presc_q     <= '0;
         d_q         <= 4'd0;
         blink_q     <= 1'b0;
         start_dly_q <= 1'b0;
         pause_dly_q <= 1'b0;
         start_arm_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         d_q         <= d_d;
         blink_q     <= blink_d;
         start_dly_q <= start_dly_d;
         pause_dly_q <= pause_dly_d;
         start_arm_q <= start_arm_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      presc_d     = presc_q;
      d_d         = d_q;
      blink_d     = blink_q;
      start_dly_d = start;
      pause_dly_d = pause;
      start_arm_d = start_arm_q | ~start;

      if (clear) begin
         state_d = ST_IDLE;
         presc_d = '0;
         blink_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               presc_d = '0;
               blink_d = 1'b0;
               if (start_edge) begin
                  state_d = ST_LOAD;
                  d_d     = preset;
               end
            end
            ST_LOAD: begin
               presc_d = '0;
               blink_d = 1'b0;
               state_d = ST_RUN;
            end
            ST_RUN: begin
               presc_d = presc_inc;
               if (start_edge) begin
                  state_d = ST_LOAD;
                  d_d     = preset;
               end else if (q_zero) begin
                  state_d = ST_DONE;
               end else if (pause_edge) begin
                  state_d = ST_PAUSE;
               end
            end
            ST_PAUSE: begin
               if (start_edge) begin
                  state_d = ST_LOAD;
                  d_d     = preset;
               end else if (pause_edge) begin
                  state_d = ST_RUN;
               end
            end
            ST_DONE: begin
               presc_d = presc_inc;
               if (presc_wrap) begin
                  blink_d = ~blink_q;
               end
               if (start_edge) begin
                  state_d = ST_LOAD;
                  d_d     = preset;
               end
            end
            default: begin
               state_d = ST_IDLE;
               presc_d = '0;
               blink_d = 1'b0;
            end
         endcase
      end
   end

   // CEP is gated by clear as well: the counter is being zeroed that cycle.
   assign CEP  = (state_q == ST_RUN) && presc_wrap && !q_zero && !clear;
   assign PEn  = (state_q != ST_LOAD);
   assign MRn  = ~clear;
   assign LTN  = ~lamp_test;
   assign BIN  = (state_q == ST_DONE) ? blink_q : 1'b1;
   assign busy = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_PAUSE);
   assign done = (state_q == ST_DONE);
   assign D    = d_q;

endmodule

// File: doc/countdown_timer_ctrl.md
COUNTDOWN_TIMER_CTRL -- requirements
Module: countdown_timer_ctrl

Interface
REQ-001 SHALL provide parameter TICK_DIV, default 50000000: CP cycles per count tick (1 Hz at 50 MHz); legal range 2..2^PRESC_W.
REQ-002 SHALL provide parameter PRESC_W, default 26: prescaler register width.
REQ-003 SHALL provide port CP  input  1: single system clock; all state updates on its rising edge.
REQ-004 SHALL provide port rstn  input  1: reset, asynchronous, active-low.
REQ-005 SHALL provide port start  input  1: level; a rising edge starts or restarts the countdown.
REQ-006 SHALL provide port pause  input  1: level; a rising edge toggles RUN/PAUSE.
REQ-007 SHALL provide port clear  input  1: level, synchronous abort to IDLE.
REQ-008 SHALL provide port lamp_test  input  1: active-high display lamp test request.
REQ-009 SHALL provide port preset  input  4: countdown start value (D,C,B,A).
REQ-010 SHALL provide port q  input  4: current value of the controlled down-counter.
REQ-011 SHALL provide port D  output  4: parallel-load data to the counter.
REQ-012 SHALL provide port PEn  output  1: counter parallel load, active-low.
REQ-013 SHALL provide port CEP  output  1: counter count enable, one-cycle pulse per tick.
REQ-014 SHALL provide port MRn  output  1: counter synchronous clear, active-low.
REQ-015 SHALL provide port LTN  output  1: decoder lamp test, active-low.
REQ-016 SHALL provide port BIN  output  1: decoder blanking, active-low.
REQ-017 SHALL provide port busy  output  1: high in LOAD, RUN, PAUSE.
REQ-018 SHALL provide port done  output  1: high in DONE.

Function
REQ-019 SHALL detect start/pause edges as in & ~in_d, with in_d registered each CP cycle; an edge seen in cycle n acts at the end of cycle n.
REQ-020 SHALL implement states IDLE, LOAD, RUN, PAUSE, DONE.
REQ-021 SHALL, with clear=1 in any state: go to IDLE next cycle, drive MRn=0 combinationally during that cycle, zero the prescaler; clear overrides start and pause.
REQ-022 SHALL go IDLE->LOAD on start edge, capturing preset into the D register on the same edge.
REQ-023 SHALL drive PEn=0 during exactly the single LOAD cycle; LOAD->RUN unconditionally, prescaler cleared to 0.
REQ-024 SHALL, in RUN, increment the prescaler 0..TICK_DIV-1 and wrap to 0; CEP=1 only in cycles where prescaler==TICK_DIV-1 and q!=0.
REQ-025 SHALL go RUN->DONE in the first RUN cycle that samples q==0, issuing no CEP in that cycle (a preset of 0 therefore yields zero CEP pulses).
REQ-026 SHALL go RUN->PAUSE on pause edge; prescaler holds its value, CEP=0; PAUSE->RUN on next pause edge, resuming from the held prescaler value.
REQ-027 SHALL, on a start edge in RUN, PAUSE or DONE, go to LOAD (restart with current preset); a start edge takes priority over a simultaneous pause edge.
REQ-028 SHALL, in DONE, keep the prescaler running and toggle a blink flag on each wrap; BIN = blink flag (display flashes 0); pause edges are ignored.
REQ-029 SHALL drive BIN=1 in all states other than DONE.
REQ-030 SHALL drive LTN = ~lamp_test combinationally in every state, independent of the FSM.
REQ-031 SHALL never assert PEn=0 and CEP=1 in the same cycle.

Reset
REQ-032 SHALL, while rstn=0, immediately force state=IDLE, prescaler=0, D=0, blink=0, start_d=pause_d=0.
REQ-033 SHALL give reset output values PEn=1, CEP=0, MRn=~clear, BIN=1, LTN=~lamp_test, busy=0, done=0.
REQ-034 SHALL ignore a start level already high at reset release until it falls and rises again.

Verification (TICK_DIV=4; bench includes a behavioural 4-bit down-counter driven by D/PEn/CEP/MRn)
REQ-035 SHALL cover: rstn low 2 cycles -> all outputs at REQ-033 values, state IDLE.
REQ-036 SHALL cover: preset=4'b0110, start edge -> PEn low exactly 1 cycle, then CEP every 4th cycle, exactly 6 pulses, done=1 the cycle after q==0, BIN toggling every 4 cycles.
REQ-037 SHALL cover: pause edge after 2nd CEP, hold 10 cycles, pause edge -> no CEP while paused, same prescaler phase on resume, 6 CEP total.
REQ-038 SHALL cover: preset=0, start edge -> LOAD, RUN 1 cycle, DONE; zero CEP pulses.
REQ-039 SHALL cover: clear=1 during RUN -> MRn=0 that cycle, IDLE next cycle, busy=0, q=0; then start edge plus simultaneous pause edge -> LOAD.
REQ-040 SHALL cover: rstn dropped mid-RUN, between CP edges -> busy=0, CEP=0 asynchronously, before the next CP edge.
